// File: rtl/inv_dir_unit.sv
// inv_dir_unit: per-lane fixed-point reciprocal for ray setup.
//   Computes inv_out[i] = 1.0 / dir_in[i] (Q_BITS fraction bits, two's complement) for LANES
//   lanes in lockstep. It uses a restoring divider that produces one quotient bit per cycle.
//   Zero lanes and out-of-range results saturate.
// Ports:
//   clk        clock, all logic on posedge
//   reset      synchronous active-low reset
//   in_valid   dir_in valid            in_ready   unit idle, can accept a vector
//   dir_in     lane i at [i*WIDTH +: WIDTH]
//   out_valid  result valid            out_ready  downstream accepts result
//   inv_out    reciprocals, same packing as dir_in
//   zero_mask  bit i set when lane i input was zero (result forced to MAX)
//   busy       state is not idle
module inv_dir_unit #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned Q_BITS = 12,
   parameter int unsigned LANES  = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*WIDTH-1:0]   dir_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*WIDTH-1:0]   inv_out,
   output logic [LANES-1:0]         zero_mask,
   output logic                     busy
);

   localparam int unsigned ITER = 2 * Q_BITS + 1;  // quotient bits of 2^(2*Q_BITS) / m
   localparam int unsigned CW   = $clog2(ITER);
   localparam int unsigned MW   = WIDTH + 1;       // magnitude width, holds |MIN|
   localparam int unsigned RW   = WIDTH + 2;       // partial remainder, up to 2*m

   localparam logic [WIDTH-1:0] MAX     = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN     = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [ITER-1:0]  POS_LIM = {{(ITER-WIDTH){1'b0}}, MAX};
   localparam logic [ITER-1:0]  NEG_LIM = {{(ITER-WIDTH){1'b0}}, MIN};  // 2^(WIDTH-1)
   localparam logic [CW-1:0]    LAST    = CW'(ITER - 1);

   typedef enum logic [1:0] {StIdle, StDivide, StDone} state_e;

   state_e                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [MW-1:0]            mag_q [LANES];
   logic [MW-1:0]            mag_d [LANES];
   logic [RW-1:0]            rem_q [LANES];
   logic [RW-1:0]            rem_d [LANES];
   logic [ITER-1:0]          quo_q [LANES];
   logic [ITER-1:0]          quo_d [LANES];
   logic [LANES-1:0]         neg_q, neg_d;
   logic [LANES-1:0]         zero_q, zero_d;
   logic [LANES*WIDTH-1:0]   inv_out_q, inv_out_d;
   logic [LANES-1:0]         zero_mask_q, zero_mask_d;
   logic                     out_valid_q, out_valid_d;

   // One restoring step per lane, plus the saturated result of that step.
   logic [RW-1:0]            rem_sh   [LANES];
   logic [RW-1:0]            step_rem [LANES];
   logic [ITER-1:0]          step_quo [LANES];
   logic [LANES*WIDTH-1:0]   res_all;

   // Input lane decode for the accept cycle.
   logic [MW-1:0]            in_mag  [LANES];
   logic [LANES-1:0]         in_neg;
   logic [LANES-1:0]         in_zero;

   always_comb begin
      res_all = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         // Dividend is 2^(2*Q_BITS): its only set bit enters on the first step.
         rem_sh[i] = {rem_q[i][RW-2:0], (cnt_q == '0)};
         if (rem_sh[i] >= {1'b0, mag_q[i]}) begin
            step_rem[i] = rem_sh[i] - {1'b0, mag_q[i]};
            step_quo[i] = {quo_q[i][ITER-2:0], 1'b1};
         end else begin
            step_rem[i] = rem_sh[i];
            step_quo[i] = {quo_q[i][ITER-2:0], 1'b0};
         end

         if (zero_q[i]) begin
            res_all[i*WIDTH +: WIDTH] = MAX;
         end else if (!neg_q[i]) begin
            res_all[i*WIDTH +: WIDTH] = (step_quo[i] > POS_LIM) ? MAX : step_quo[i][WIDTH-1:0];
         end else begin
            res_all[i*WIDTH +: WIDTH] = (step_quo[i] > NEG_LIM) ? MIN : -step_quo[i][WIDTH-1:0];
         end

         in_neg[i]  = dir_in[i*WIDTH + WIDTH - 1];
         in_zero[i] = (dir_in[i*WIDTH +: WIDTH] == '0);
         // Sign-extend before negating so MIN maps to +2^(WIDTH-1).
         in_mag[i]  = in_neg[i] ? -{dir_in[i*WIDTH + WIDTH - 1], dir_in[i*WIDTH +: WIDTH]}
                                :  {1'b0, dir_in[i*WIDTH +: WIDTH]};
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mag_d       = mag_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      neg_d       = neg_q;
      zero_d      = zero_q;
      inv_out_d   = inv_out_q;
      zero_mask_d = zero_mask_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               cnt_d  = '0;
               neg_d  = in_neg;
               zero_d = in_zero;
               for (int unsigned i = 0; i < LANES; i++) begin
                  mag_d[i] = in_mag[i];
                  rem_d[i] = '0;
                  quo_d[i] = '0;
               end
               if (&in_zero) begin
                  state_d     = StDone;
                  inv_out_d   = {LANES{MAX}};
                  zero_mask_d = in_zero;
                  out_valid_d = 1'b1;
               end else begin
                  state_d = StDivide;
               end
            end
         end

         StDivide: begin
            for (int unsigned i = 0; i < LANES; i++) begin
               if (!zero_q[i]) begin  // zero lanes keep their divider quiet
                  rem_d[i] = step_rem[i];
                  quo_d[i] = step_quo[i];
               end
            end
            if (cnt_q == LAST) begin
               cnt_d       = '0;
               state_d     = StDone;
               inv_out_d   = res_all;
               zero_mask_d = zero_q;
               out_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StDone: begin
            if (out_ready) begin
               state_d     = StIdle;
               out_valid_d = 1'b0;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         neg_q       <= '0;
         zero_q      <= '0;
         inv_out_q   <= '0;
         zero_mask_q <= '0;
         out_valid_q <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) begin
            mag_q[i] <= '0;
            rem_q[i] <= '0;
            quo_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         neg_q       <= neg_d;
         zero_q      <= zero_d;
         inv_out_q   <= inv_out_d;
         zero_mask_q <= zero_mask_d;
         out_valid_q <= out_valid_d;
         for (int unsigned i = 0; i < LANES; i++) begin
            mag_q[i] <= mag_d[i];
            rem_q[i] <= rem_d[i];
            quo_q[i] <= quo_d[i];
         end
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign out_valid = out_valid_q;
   assign inv_out   = inv_out_q;
   assign zero_mask = zero_mask_q;

endmodule

// File: tb/tb_inv_dir_unit.sv
// Directed bench for inv_dir_unit: hand-computed reciprocals, latency, hold and reset cases.
module tb_inv_dir_unit;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [47:0]   dir_in;
   logic          out_valid;
   logic          out_ready;
   logic [47:0]   inv_out;
   logic [2:0]    zero_mask;
   logic          busy;

   int n_checks;
   int n_fail;

   inv_dir_unit dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dir_in    (dir_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .inv_out   (inv_out),
      .zero_mask (zero_mask),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one vector for one accepting edge, then wait (bounded) for out_valid.
   // lat is the spec's cycle number: 1 means visible right after the accept edge.
   task automatic send(input logic [47:0] v, output int lat);
      @(negedge clk);
      in_valid = 1'b1;
      dir_in   = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dir_in   = 48'h5A5A_A5A5_1234;  // outside the accept cycle, must be ignored
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_out(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_val({tag, "_idle_ready"}, in_ready, 1);
      check_val({tag, "_idle_valid"}, out_valid, 0);
      check_val({tag, "_idle_busy"}, busy, 0);
   endtask

   task automatic run_vec(input string tag, input logic [47:0] v, input logic [47:0] exp_inv,
                          input logic [2:0] exp_mask, input int exp_lat);
      int lat;
      send(v, lat);
      check_val({tag, "_lat"}, lat, exp_lat);
      check_val({tag, "_inv"}, inv_out, exp_inv);
      check_val({tag, "_mask"}, zero_mask, exp_mask);
      release_out(tag);
   endtask

   initial begin
      int          lat;
      logic [47:0] snap_inv;
      logic [2:0]  snap_mask;
      logic        stable;
      logic        never_ready;

      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dir_in    = '0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_inv_out", inv_out, 0);
      check_val("rst_zero_mask", zero_mask, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_in_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b1;

      // Lanes packed {z, y, x}.
      run_vec("v1", {16'hE000, 16'h0800, 16'h1000}, {16'hF800, 16'h2000, 16'h1000}, 3'b000, 26);
      run_vec("v2", {16'h0000, 16'h1000, 16'h0000}, {16'h7FFF, 16'h1000, 16'h7FFF}, 3'b101, 26);
      run_vec("v3", 48'h0, {16'h7FFF, 16'h7FFF, 16'h7FFF}, 3'b111, 1);
      // x: 2^24 > MAX; y: -1 -> q=2^24 -> MIN; z: MIN input, m=2^15, q=512 -> -512.
      run_vec("v4", {16'h8000, 16'hFFFF, 16'h0001}, {16'hFE00, 16'h8000, 16'h7FFF}, 3'b000, 26);
      // 2^24/12288 = 1365 (truncated); -1365 = FAAB; m=512 negative gives q=2^15 -> 8000.
      run_vec("v5", {16'hFE00, 16'hD000, 16'h3000}, {16'h8000, 16'hFAAB, 16'h0555}, 3'b000, 26);

      // Backpressure: outputs held, no acceptance even with in_valid high.
      send({16'h0000, 16'h0800, 16'h1000}, lat);
      check_val("hold_lat", lat, 26);
      snap_inv    = inv_out;
      snap_mask   = zero_mask;
      stable      = 1'b1;
      never_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1;
      dir_in   = {16'h1000, 16'h1000, 16'h1000};
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (inv_out !== snap_inv || zero_mask !== snap_mask || out_valid !== 1'b1) stable = 1'b0;
         if (in_ready !== 1'b0) never_ready = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check_val("hold_stable", stable, 1);
      check_val("hold_in_ready_low", never_ready, 1);
      check_val("hold_inv", snap_inv, {16'h7FFF, 16'h2000, 16'h1000});
      check_val("hold_mask", snap_mask, 3'b100);
      release_out("hold");

      // out_ready high before out_valid: result still appears and retires next edge.
      @(negedge clk);
      out_ready = 1'b1;
      send({16'h7FFF, 16'h0200, 16'h0201}, lat);
      check_val("early_lat", lat, 26);
      check_val("early_inv", inv_out, {16'h0200, 16'h7FFF, 16'h7FC0});
      @(posedge clk);
      #1;
      check_val("early_retired", out_valid, 0);
      check_val("early_in_ready", in_ready, 1);
      @(negedge clk);
      out_ready = 1'b0;

      // Reset during the division: discarded, outputs cleared.
      send({16'hE000, 16'h0800, 16'h1000}, lat);
      check_val("pre_rst_inv", inv_out, {16'hF800, 16'h2000, 16'h1000});
      release_out("pre_rst");
      @(negedge clk);
      in_valid = 1'b1;
      dir_in   = {16'h3000, 16'h3000, 16'h3000};
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_val("mid_busy", busy, 1);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_in_ready", in_ready, 1);
      check_val("mid_rst_out_valid", out_valid, 0);
      check_val("mid_rst_inv", inv_out, 0);
      check_val("mid_rst_mask", zero_mask, 0);
      @(negedge clk);
      reset = 1'b1;
      run_vec("post_rst", {16'hD000, 16'h0001, 16'h3000}, {16'hFAAB, 16'h7FFF, 16'h0555},
              3'b000, 26);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
